// File: rtl/vfu_slot_pkg.sv
// Shared types for the VFU slot request path: the slot request payload,
// its field widths and the index-width helper used by the arbiter.
package vfu_slot_pkg;

   localparam int unsigned SRC_W      = 33;
   localparam int unsigned OPCODE_W   = 4;
   localparam int unsigned MASK_W     = 4;
   localparam int unsigned VXRM_W     = 2;
   localparam int unsigned VSEW_W     = 2;
   localparam int unsigned EXEC_IDX_W = 2;
   localparam int unsigned TAG_W      = 2;

   // Everything in a request except the two source operands.
   localparam int unsigned CTRL_W = OPCODE_W + MASK_W + 4 + VXRM_W + VSEW_W
                                    + EXEC_IDX_W + TAG_W;

   typedef struct packed {
      logic [SRC_W-1:0]      src_0;
      logic [SRC_W-1:0]      src_1;
      logic [OPCODE_W-1:0]   opcode;
      logic [MASK_W-1:0]     mask;
      logic                  sign;
      logic                  reverse;
      logic                  average;
      logic                  saturate;
      logic [VXRM_W-1:0]     vxrm;
      logic [VSEW_W-1:0]     vSew;
      logic [EXEC_IDX_W-1:0] executeIndex;
      logic [TAG_W-1:0]      tag;
   } slot_req_t;

   // A single slot still needs a one-bit index field.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/slot_request_arbiter_if.sv
// Slot-side request bundle and VFU-side output bundle of the slot arbiter.
// The arbiter connects through the slave modport.
interface slot_request_arbiter_if
   import vfu_slot_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 4
);
   localparam int unsigned IDX_W = idx_width(NUM_SLOTS);

   logic [NUM_SLOTS-1:0] in_valid;
   logic [NUM_SLOTS-1:0] in_ready;
   slot_req_t            in_bits [NUM_SLOTS];

   logic                 out_valid;
   logic                 out_ready;
   slot_req_t            out_bits;
   logic [IDX_W-1:0]     out_chosen;

   modport master (
      output in_valid, in_bits, out_ready,
      input  in_ready, out_valid, out_bits, out_chosen
   );

   modport slave (
      input  in_valid, in_bits, out_ready,
      output in_ready, out_valid, out_bits, out_chosen
   );

endinterface

// File: rtl/slot_request_arbiter_rr_select.sv
// Combinational picker: first valid index at or after ptr (rotating mode)
// or lowest valid index (fixed mode), as one-hot grant plus encoded index.
module rr_select #(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned IDX_W     = 2
) (
   input  logic [NUM_SLOTS-1:0] valid,
   input  logic [IDX_W-1:0]     ptr,
   input  logic                 round_robin,
   output logic [NUM_SLOTS-1:0] grant,
   output logic [IDX_W-1:0]     index,
   output logic                 any_valid
);

   int unsigned      base;
   int unsigned      cand;
   logic [IDX_W-1:0] idx;

   always_comb begin
      // NOTE: every output and temporary gets a default before the scan so
      // each path assigns everything and no latch can be inferred.
      grant     = '0;
      index     = '0;
      any_valid = 1'b0;
      cand      = 0;
      idx       = '0;
      base      = round_robin ? 32'(ptr) : 32'd0;
      if (base >= NUM_SLOTS) base = 32'd0;

      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         cand = base + k;
         if (cand >= NUM_SLOTS) cand = cand - NUM_SLOTS;
         idx = IDX_W'(cand);
         if (!any_valid && valid[idx]) begin
            any_valid  = 1'b1;
            grant[idx] = 1'b1;
            index      = idx;
         end
      end
   end

endmodule

// File: rtl/slot_request_arbiter.sv
// N-way slot arbiter feeding one VFU through a 2-entry output queue.
// Acceptance depends only on queue occupancy, so out_ready never reaches in_ready.
module slot_request_arbiter
   import vfu_slot_pkg::*;
#(
   parameter int unsigned NUM_SLOTS   = 4,
   parameter bit          ROUND_ROBIN = 1'b1,
   parameter int unsigned SRC_W       = vfu_slot_pkg::SRC_W
) (
   input logic                   clock,
   input logic                   reset,
   slot_request_arbiter_if.slave bus
);

   localparam int unsigned IDX_W     = idx_width(NUM_SLOTS);
   localparam int unsigned PAYLOAD_W = 2 * SRC_W + CTRL_W;

   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      logic [IDX_W-1:0]     chosen;
   } entry_t;

   logic [NUM_SLOTS-1:0] grant;
   logic [IDX_W-1:0]     winner;
   logic [IDX_W-1:0]     rr_ptr;
   logic                 any_valid;
   logic                 space;
   logic                 push;
   logic                 pop;
   logic                 head;
   logic                 tail;
   logic [1:0]           count;
   entry_t               q_mem [2];

   rr_select #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) u_rr_select (
      .valid       (bus.in_valid),
      .ptr         (rr_ptr),
      .round_robin (ROUND_ROBIN),
      .grant       (grant),
      .index       (winner),
      .any_valid   (any_valid)
   );

   // A full queue refuses input even when the head leaves this cycle.
   assign space        = (count < 2'd2);
   assign bus.in_ready = grant & {NUM_SLOTS{space}};
   assign push         = any_valid & space;
   assign pop          = bus.out_valid & bus.out_ready;

   always_ff @(posedge clock or negedge reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      if (!reset) begin
         count <= 2'd0;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (push) tail <= ~tail;
         if (pop)  head <= ~head;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   generate
      if (ROUND_ROBIN) begin : g_rr_ptr
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               rr_ptr <= '0;
            end else if (push) begin
               rr_ptr <= (winner == IDX_W'(NUM_SLOTS - 1)) ? '0 : winner + 1'b1;
            end
         end
      end else begin : g_fixed_ptr
         assign rr_ptr = '0;
      end
   endgenerate

   // NOTE: queue storage has no reset; count alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (push) begin
         q_mem[tail] <= '{payload: bus.in_bits[winner], chosen: winner};
      end
   end

   assign bus.out_valid  = (count != 2'd0);
   assign bus.out_bits   = slot_req_t'(q_mem[head].payload);
   assign bus.out_chosen = bus.out_valid ? q_mem[head].chosen : '0;

endmodule

// File: tb/tb_slot_request_arbiter.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops
// and compares on every output fire of the rotating-priority instance.
module tb_slot_request_arbiter;
   import vfu_slot_pkg::*;

   localparam int N = 4;

   typedef struct {
      slot_req_t  bits;
      logic [1:0] chosen;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic tb_ordy;
   slot_req_t tb_bits [N];

   int n_tests = 0;
   int n_fail  = 0;
   int seq     = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   slot_request_arbiter_if #(.NUM_SLOTS(N)) rr_if ();
   slot_request_arbiter_if #(.NUM_SLOTS(N)) fp_if ();

   assign rr_if.in_bits   = tb_bits;
   assign fp_if.in_bits   = tb_bits;
   assign rr_if.out_ready = tb_ordy;
   assign fp_if.out_ready = tb_ordy;

   slot_request_arbiter #(.NUM_SLOTS(N), .ROUND_ROBIN(1'b1), .SRC_W(33)) u_dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (rr_if.slave)
   );

   slot_request_arbiter #(.NUM_SLOTS(N), .ROUND_ROBIN(1'b0), .SRC_W(33)) u_fixed (
      .clock (clk),
      .reset (rst_n),
      .bus   (fp_if.slave)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic slot_req_t make_req(input int slot, input int s);
      slot_req_t   r;
      logic [31:0] sv = 32'(s);
      r.src_0        = {sv[0], 32'(s * 256 + slot * 17 + 1)};
      r.src_1        = {~sv[0], 32'hA5A5_0000 ^ sv};
      r.opcode       = 4'(s + slot);
      r.mask         = 4'(1 << slot);
      r.sign         = sv[1];
      r.reverse      = sv[2];
      r.average      = 1'(slot);
      r.saturate     = ~sv[1];
      r.vxrm         = 2'(slot);
      r.vSew         = 2'(s);
      r.executeIndex = 2'(s + 1);
      r.tag          = 2'(slot + s);
      return r;
   endfunction

   // Monitor: every output fire of the rotating instance is scored.
   always @(negedge clk) begin
      if (rst_n && rr_if.out_valid && tb_ordy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 1'b1, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_bits", rr_if.out_bits, mon_e.bits);
            check("out_chosen", rr_if.out_chosen, mon_e.chosen);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      seq++;
   endtask

   // Drive one cycle, check acceptance and out_valid, score the expected push.
   task automatic drive(input logic [3:0] valid, input logic ordy, input logic [3:0] exp_ready,
                        input logic exp_ov, input string tag);
      int w;
      rr_if.in_valid = valid;
      tb_ordy        = ordy;
      for (int i = 0; i < N; i++) tb_bits[i] = make_req(i, seq);
      @(negedge clk);
      check({tag, "_in_ready"}, rr_if.in_ready, exp_ready);
      check({tag, "_out_valid"}, rr_if.out_valid, exp_ov);
      if (exp_ready != 4'b0000) begin
         w = 0;
         for (int i = 0; i < N; i++) if (exp_ready[i]) w = i;
         exp_q.push_back('{bits: tb_bits[w], chosen: 2'(w)});
      end
   endtask

   task automatic apply_reset();
      rst_n          = 1'b0;
      rr_if.in_valid = '0;
      fp_if.in_valid = '0;
      tb_ordy        = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit after %0d tests", n_tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      slot_req_t special;
      int        s0;

      rst_n          = 1'b0;
      rr_if.in_valid = '0;
      fp_if.in_valid = '0;
      tb_ordy        = 1'b0;
      for (int i = 0; i < N; i++) tb_bits[i] = make_req(i, 0);
      #1;
      check("reset_out_valid", rr_if.out_valid, 1'b0);
      check("reset_in_ready", rr_if.in_ready, 4'b0000);
      check("reset_out_chosen", rr_if.out_chosen, 2'd0);
      check("reset_fp_out_valid", fp_if.out_valid, 1'b0);
      apply_reset();

      // Single request on slot 2, visible the next cycle.
      special        = make_req(2, seq);
      special.src_0  = 33'h1_0000_0001;
      special.tag    = 2'd3;
      rr_if.in_valid = 4'b0100;
      tb_ordy        = 1'b1;
      for (int i = 0; i < N; i++) tb_bits[i] = make_req(i, seq);
      tb_bits[2] = special;
      @(negedge clk);
      check("single_in_ready", rr_if.in_ready, 4'b0100);
      check("single_out_valid_early", rr_if.out_valid, 1'b0);
      exp_q.push_back('{bits: special, chosen: 2'd2});
      tick();
      drive(4'b0000, 1'b1, 4'b0000, 1'b1, "single_latency");
      check("single_chosen", rr_if.out_chosen, 2'd2);
      tick();
      drive(4'b0000, 1'b1, 4'b0000, 1'b0, "single_drained");
      tick();

      // Rotating priority, all slots valid, one output per cycle.
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         drive(4'b1111, 1'b1, 4'(1 << (k % 4)), (k != 0), "rr_order");
         tick();
      end
      drive(4'b0000, 1'b1, 4'b0000, 1'b1, "rr_tail");
      tick();
      drive(4'b0000, 1'b1, 4'b0000, 1'b0, "rr_empty");
      tick();

      // Fixed priority: slot 1 always beats slot 3.
      rr_if.in_valid = '0;
      for (int k = 0; k < 6; k++) begin
         fp_if.in_valid = 4'b1010;
         tb_ordy        = 1'b1;
         for (int i = 0; i < N; i++) tb_bits[i] = make_req(i, seq);
         @(negedge clk);
         check("fp_in_ready", fp_if.in_ready, 4'b0010);
         if (k > 0) begin
            check("fp_out_valid", fp_if.out_valid, 1'b1);
            check("fp_out_chosen", fp_if.out_chosen, 2'd1);
            check("fp_out_bits", fp_if.out_bits, make_req(1, seq - 1));
         end
         tick();
      end
      fp_if.in_valid = '0;
      tick();

      // Backpressure: two entries accepted, then full; drain in order.
      s0 = seq;
      drive(4'b0001, 1'b0, 4'b0001, 1'b0, "bp_first");
      tick();
      drive(4'b0001, 1'b0, 4'b0001, 1'b1, "bp_second");
      check("bp_hold_bits", rr_if.out_bits, make_req(0, s0));
      tick();
      for (int k = 0; k < 2; k++) begin
         drive(4'b0001, 1'b0, 4'b0000, 1'b1, "bp_full");
         check("bp_hold_bits", rr_if.out_bits, make_req(0, s0));
         check("bp_hold_chosen", rr_if.out_chosen, 2'd0);
         tick();
      end
      drive(4'b0001, 1'b1, 4'b0000, 1'b1, "bp_full_pop");
      tick();
      drive(4'b0001, 1'b1, 4'b0001, 1'b1, "bp_reopen");
      tick();

      // Occupancy 1 with push and pop every cycle.
      for (int k = 0; k < 10; k++) begin
         drive(4'(1 << (k % 4)), 1'b1, 4'(1 << (k % 4)), 1'b1, "steady");
         tick();
      end
      drive(4'b0000, 1'b1, 4'b0000, 1'b1, "steady_tail");
      tick();
      drive(4'b0000, 1'b1, 4'b0000, 1'b0, "steady_empty");
      tick();
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      // Reset with a full queue, then rr_ptr must restart at 0.
      drive(4'b0100, 1'b0, 4'b0100, 1'b0, "fill_a");
      tick();
      drive(4'b0100, 1'b0, 4'b0100, 1'b1, "fill_b");
      tick();
      check("fill_full_ready", rr_if.in_ready, 4'b0000);
      rr_if.in_valid = '0;
      rst_n          = 1'b0;
      exp_q.delete();
      #1;
      check("reset_midop_out_valid", rr_if.out_valid, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(4'b1110, 1'b1, 4'b0010, 1'b0, "post_reset");
      tick();
      drive(4'b0000, 1'b1, 4'b0000, 1'b1, "post_reset_out");
      tick();
      drive(4'b0000, 1'b1, 4'b0000, 1'b0, "post_reset_empty");
      tick();
      check("final_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/slot_request_arbiter.md
# slot_request_arbiter

Parametrised N-way arbiter with a buffered output stage for slot requests headed to a vector functional unit (VFU). It sits between the lane's execution slots and one shared VFU. Each cycle it picks one valid slot request, in round-robin or fixed-priority order, and moves it unmodified into a 2-entry output queue. The queue decouples the VFU's ready from the slots' ready paths.

## Interface
Parameters:
- NUM_SLOTS, 4: number of requesting slots, ≥1.
- ROUND_ROBIN, 1: 1 selects rotating priority; 0 selects fixed priority, lowest index wins.
- SRC_W, 33: width of each source operand (data plus sign-extension bit).

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; state clears while low.
- in_valid  input  NUM_SLOTS  per-slot request valid.
- in_ready  output  NUM_SLOTS  per-slot accept; one-hot or zero.
- in_bits  input  NUM_SLOTS × slot_req_t  per-slot payload.
- out_valid  output  1  head of output queue is valid.
- out_ready  input  1  VFU accepts the head.
- out_bits  output  slot_req_t  head payload.
- out_chosen  output  $clog2(NUM_SLOTS), min 1  slot index that issued the head entry.

Payload fields:
- slot_req_t: src_0 and src_1 (SRC_W each), opcode[4], mask[4], sign, reverse, average, saturate, vxrm[2], vSew[2], executeIndex[2], tag[2].

## Operation
- Input fire: in_valid[i] && in_ready[i]. Output fire: out_valid && out_ready.
- Arbitration is combinational over in_valid.
  - ROUND_ROBIN=1: the winner is the first valid index at or after rr_ptr, scanning upward with wrap to 0.
  - ROUND_ROBIN=0: the winner is the lowest valid index, and rr_ptr is ignored.
- in_ready[winner] = space. All other in_ready bits are 0.
  - space = (count < 2).
  - space is a function of registered state only. out_ready never combinationally reaches in_ready.
- On input fire, {in_bits[winner], winner} is written to the queue tail. The payload is passed bit-exact.
- On input fire with ROUND_ROBIN=1, rr_ptr <= (winner + 1) mod NUM_SLOTS. With no fire, rr_ptr holds.
- The queue is a 2-entry FIFO with head/tail pointers and count ∈ {0,1,2}.
  - out_valid = (count ≠ 0).
  - out_bits and out_chosen are driven from the head entry.
- A request withdrawn before it fires is legal. A slot that loses arbitration simply retries; the arbiter keeps no per-slot state.
- NUM_SLOTS=1 degenerates to a single-input queue: in_ready[0] = space, and out_chosen is always 0.

## Timing
- Reset (reset low, asynchronous):
  - count=0, head=0, tail=0, rr_ptr=0.
  - Outputs: out_valid=0, in_ready=0 only if no slot is valid, out_chosen=0.
  - Queue storage need not be cleared.
- Latency: an input fire in cycle t makes that entry visible at the output in cycle t+1 when the queue was empty.
- Throughput: one request per cycle sustained while out_ready=1.
- Empty queue (count=0): push only.
- Full queue (count=2): in_ready=0 for all slots, even if an output fire happens in the same cycle. Space reopens the next cycle.
- count=1 with a simultaneous push and pop: count stays 1, head and tail both advance, and ordering is preserved.
- Output hold: while out_valid && !out_ready, out_bits and out_chosen hold stable.
- Pointer wrap: head and tail wrap modulo 2. rr_ptr wraps from NUM_SLOTS-1 to 0.
- Reset asserted mid-operation: queued entries are discarded, and out_valid drops immediately.

## Structure
- Package vfu_slot_pkg holds:
  - the slot_req_t packed struct, with the SRC_W default;
  - the field widths for opcode, mask, vxrm, vSew, executeIndex and tag.
- Sub-module rr_select: a combinational round-robin picker.
  - Inputs: valid vector, pointer, mode.
  - Outputs: one-hot grant, encoded index, any-valid.
- The queue is inline in the top module.

## Test plan
- Reset, then a single request on slot 2 with src_0=0x1_0000_0001 and tag=3 → output in the next cycle with identical bits and out_chosen=2.
- ROUND_ROBIN=1, all four slots continuously valid, out_ready=1 → grant order 0,1,2,3,0,… and one output per cycle.
- ROUND_ROBIN=0, slots 1 and 3 valid → slot 1 is always granted and slot 3 is never granted.
- out_ready=0 for 4 cycles with slot 0 valid → two entries accepted, then in_ready=0. Raise out_ready → the entries drain in order, and in_ready returns the cycle after the first pop.
- count=1 with simultaneous push and pop, repeated 10 cycles → count stays 1 and no entry is lost or reordered.
- Assert reset low with count=2 → out_valid=0 immediately. After release, the first grant goes to the lowest valid index (rr_ptr=0).
